// File: rtl/jt10_adpcm_rom_arb_if.sv
// Byte-wide sample ROM port between the ADPCM arbiter (master) and the board
// memory controller (slave): level request, one-cycle completion pulse.
interface jt10_adpcm_rom_arb_if;
   logic [24:0] rom_addr;
   logic        rom_req;
   logic        rom_ok;
   logic [7:0]  rom_data;

   modport master (output rom_addr, output rom_req, input rom_ok, input rom_data);
   modport slave  (input rom_addr, input rom_req, output rom_ok, output rom_data);
endinterface

// File: rtl/jt10_adpcm_rom_arb.sv
// Shares one byte-wide sample ROM between the YM2610 ADPCM-A and ADPCM-B fetch
// ports, with a one-entry address tag per channel and round-robin on contention.
module jt10_adpcm_rom_arb #(
   parameter logic [24:0] A_BASE = 25'h000_0000,
   parameter logic [24:0] B_BASE = 25'h100_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [19:0]                  adpcma_addr,
   input  logic [3:0]                   adpcma_bank,
   input  logic                         adpcma_roe_n,
   output logic [7:0]                   adpcma_data,
   input  logic [23:0]                  adpcmb_addr,
   input  logic                         adpcmb_roe_n,
   output logic [7:0]                   adpcmb_data,
   output logic                         busy,
   jt10_adpcm_rom_arb_if.master         rom
);

   typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B} state_t;

   state_t      state_q, state_d;
   logic [24:0] rom_addr_q, rom_addr_d;
   logic        rom_req_q, rom_req_d;
   logic [7:0]  a_data_q, a_data_d;
   logic [7:0]  b_data_q, b_data_d;
   logic [23:0] tag_a_q, tag_a_d;
   logic [23:0] tag_b_q, tag_b_d;
   logic        tag_valid_a_q, tag_valid_a_d;
   logic        tag_valid_b_q, tag_valid_b_d;
   logic [23:0] cur_tag_q, cur_tag_d;
   logic        last_grant_q, last_grant_d;   // 1 = B was granted last

   logic [23:0] fa, fb;
   logic        pend_a, pend_b;

   assign fa     = {adpcma_bank, adpcma_addr};
   assign fb     = adpcmb_addr;
   assign pend_a = !adpcma_roe_n && !(tag_valid_a_q && tag_a_q == fa);
   assign pend_b = !adpcmb_roe_n && !(tag_valid_b_q && tag_b_q == fb);

   always_comb begin
      state_d       = state_q;
      rom_addr_d    = rom_addr_q;
      rom_req_d     = rom_req_q;
      a_data_d      = a_data_q;
      b_data_d      = b_data_q;
      tag_a_d       = tag_a_q;
      tag_b_d       = tag_b_q;
      tag_valid_a_d = tag_valid_a_q;
      tag_valid_b_d = tag_valid_b_q;
      cur_tag_d     = cur_tag_q;
      last_grant_d  = last_grant_q;
      case (state_q)
         IDLE: begin
            // On a tie the channel that was not served last wins.
            if (pend_a && (!pend_b || last_grant_q)) begin
               rom_addr_d   = A_BASE + {1'b0, fa};
               rom_req_d    = 1'b1;
               cur_tag_d    = fa;
               last_grant_d = 1'b0;
               state_d      = FETCH_A;
            end else if (pend_b) begin
               rom_addr_d   = B_BASE + {1'b0, fb};
               rom_req_d    = 1'b1;
               cur_tag_d    = fb;
               last_grant_d = 1'b1;
               state_d      = FETCH_B;
            end
         end
         FETCH_A: begin
            if (rom.rom_ok) begin
               a_data_d      = rom.rom_data;
               tag_a_d       = cur_tag_q;
               tag_valid_a_d = 1'b1;
               rom_req_d     = 1'b0;
               state_d       = IDLE;
            end
         end
         FETCH_B: begin
            if (rom.rom_ok) begin
               b_data_d      = rom.rom_data;
               tag_b_d       = cur_tag_q;
               tag_valid_b_d = 1'b1;
               rom_req_d     = 1'b0;
               state_d       = IDLE;
            end
         end
         default: begin
            rom_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rom_addr_q    <= '0;
         rom_req_q     <= 1'b0;
         a_data_q      <= '0;
         b_data_q      <= '0;
         tag_a_q       <= '0;
         tag_b_q       <= '0;
         tag_valid_a_q <= 1'b0;
         tag_valid_b_q <= 1'b0;
         cur_tag_q     <= '0;
         last_grant_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         rom_addr_q    <= rom_addr_d;
         rom_req_q     <= rom_req_d;
         a_data_q      <= a_data_d;
         b_data_q      <= b_data_d;
         tag_a_q       <= tag_a_d;
         tag_b_q       <= tag_b_d;
         tag_valid_a_q <= tag_valid_a_d;
         tag_valid_b_q <= tag_valid_b_d;
         cur_tag_q     <= cur_tag_d;
         last_grant_q  <= last_grant_d;
      end
   end

   assign rom.rom_addr = rom_addr_q;
   assign rom.rom_req  = rom_req_q;
   assign adpcma_data  = a_data_q;
   assign adpcmb_data  = b_data_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb: a vector table of single-channel
// fetches plus hand-written arbitration, tag, mid-fetch change and reset cases.
module tb_jt10_adpcm_rom_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] adpcma_addr;
   logic [3:0]  adpcma_bank;
   logic        adpcma_roe_n;
   logic [7:0]  adpcma_data;
   logic [23:0] adpcmb_addr;
   logic        adpcmb_roe_n;
   logic [7:0]  adpcmb_data;
   logic        busy;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   jt10_adpcm_rom_arb_if rom_if ();

   jt10_adpcm_rom_arb dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .adpcma_addr  (adpcma_addr),
      .adpcma_bank  (adpcma_bank),
      .adpcma_roe_n (adpcma_roe_n),
      .adpcma_data  (adpcma_data),
      .adpcmb_addr  (adpcmb_addr),
      .adpcmb_roe_n (adpcmb_roe_n),
      .adpcmb_data  (adpcmb_data),
      .busy         (busy),
      .rom          (rom_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        is_b;
      logic [3:0]  bank;
      logic [23:0] addr;
      int          dly;
      logic [7:0]  data;
      logic [24:0] exp_addr;
      int          exp_lat;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for a request, then act as memory: ack after dly cycles.
   task automatic serve(input string nm, input logic [24:0] ea, input int dly,
                        input logic [7:0] d, output int reqcyc);
      int n = 0;
      while (!rom_if.rom_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({nm, " req"}, {31'd0, rom_if.rom_req}, 32'd1);
      check({nm, " addr"}, {7'd0, rom_if.rom_addr}, {7'd0, ea});
      check({nm, " busy"}, {31'd0, busy}, 32'd1);
      reqcyc = 0;
      for (int i = 0; i < dly; i++) begin
         reqcyc += int'(rom_if.rom_req);
         @(negedge clk);
         check({nm, " addr hold"}, {7'd0, rom_if.rom_addr}, {7'd0, ea});
      end
      reqcyc += int'(rom_if.rom_req);
      rom_if.rom_ok   = 1'b1;
      rom_if.rom_data = d;
      @(negedge clk);
      rom_if.rom_ok   = 1'b0;
      rom_if.rom_data = 8'h00;
      check({nm, " req drop"}, {31'd0, rom_if.rom_req}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   rc, c0, seen;
      logic [7:0] other;

      vecs[0] = '{1'b0, 4'h2, 24'h000010, 3, 8'h5A, 25'h0200010, 5};
      vecs[1] = '{1'b1, 4'h0, 24'h123456, 0, 8'hC3, 25'h1123456, 2};
      vecs[2] = '{1'b0, 4'hF, 24'h0FFFFF, 1, 8'h11, 25'h0FFFFFF, 3};
      vecs[3] = '{1'b1, 4'h0, 24'hFFFFFF, 2, 8'h22, 25'h1FFFFFF, 4};
      vecs[4] = '{1'b0, 4'h0, 24'h000000, 0, 8'h33, 25'h0000000, 2};

      adpcma_addr = '0; adpcma_bank = '0; adpcma_roe_n = 1'b1;
      adpcmb_addr = '0; adpcmb_roe_n = 1'b1;
      rom_if.rom_ok = 1'b0; rom_if.rom_data = 8'h00;
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst req",   {31'd0, rom_if.rom_req}, 32'd0);
      check("rst addr",  {7'd0, rom_if.rom_addr}, 32'd0);
      check("rst a_dat", {24'd0, adpcma_data}, 32'd0);
      check("rst b_dat", {24'd0, adpcmb_data}, 32'd0);
      check("rst busy",  {31'd0, busy}, 32'd0);

      // Single-channel fetches from the table
      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         if (v.is_b) begin
            other = adpcma_data;
            adpcmb_addr = v.addr; adpcmb_roe_n = 1'b0;
         end else begin
            other = adpcmb_data;
            adpcma_bank = v.bank; adpcma_addr = v.addr[19:0]; adpcma_roe_n = 1'b0;
         end
         c0 = cyc;
         serve($sformatf("vec%0d", i), v.exp_addr, v.dly, v.data, rc);
         check($sformatf("vec%0d reqcyc", i), rc, v.dly + 1);
         check($sformatf("vec%0d lat", i), cyc - c0, v.exp_lat);
         check($sformatf("vec%0d data", i), {24'd0, v.is_b ? adpcmb_data : adpcma_data}, {24'd0, v.data});
         check($sformatf("vec%0d other", i), {24'd0, v.is_b ? adpcma_data : adpcmb_data}, {24'd0, other});
         adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
         @(negedge clk);
      end

      // Re-read of the address just fetched: tag hit, no memory cycle
      adpcma_roe_n = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(rom_if.rom_req);
      end
      check("reread req", seen, 0);
      check("reread data", {24'd0, adpcma_data}, 32'h33);
      adpcma_roe_n = 1'b1;
      @(negedge clk);

      // Tie after reset: A first, then B
      do_reset();
      adpcma_bank = 4'h1; adpcma_addr = 20'h00100; adpcmb_addr = 24'h000200;
      adpcma_roe_n = 1'b0; adpcmb_roe_n = 1'b0;
      serve("tie1 A", 25'h0100100, 0, 8'h71, rc);
      check("tie1 A data", {24'd0, adpcma_data}, 32'h71);
      serve("tie1 B", 25'h1000200, 0, 8'h72, rc);
      check("tie1 B data", {24'd0, adpcmb_data}, 32'h72);
      adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
      @(negedge clk);
      // A alone, so the next tie goes to B
      adpcma_addr = 20'h00101; adpcma_roe_n = 1'b0;
      serve("solo A", 25'h0100101, 1, 8'h73, rc);
      adpcma_roe_n = 1'b1;
      @(negedge clk);
      adpcma_addr = 20'h00102; adpcmb_addr = 24'h000201;
      adpcma_roe_n = 1'b0; adpcmb_roe_n = 1'b0;
      serve("tie2 B", 25'h1000201, 0, 8'h74, rc);
      check("tie2 B data", {24'd0, adpcmb_data}, 32'h74);
      check("tie2 A held", {24'd0, adpcma_data}, 32'h73);
      serve("tie2 A", 25'h0100102, 0, 8'h75, rc);
      check("tie2 A data", {24'd0, adpcma_data}, 32'h75);
      adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
      @(negedge clk);

      // Address changes while FETCH_A waits: old byte lands, then new fetch
      adpcma_bank = 4'h3; adpcma_addr = 20'h00050; adpcma_roe_n = 1'b0;
      @(negedge clk);
      adpcma_addr = 20'h00051;
      serve("chg old", 25'h0300050, 2, 8'h81, rc);
      check("chg old data", {24'd0, adpcma_data}, 32'h81);
      serve("chg new", 25'h0300051, 0, 8'h82, rc);
      check("chg new data", {24'd0, adpcma_data}, 32'h82);
      adpcma_roe_n = 1'b1;
      @(negedge clk);

      // Reset during FETCH_B, then a stray ok
      adpcmb_addr = 24'h000300; adpcmb_roe_n = 1'b0;
      @(negedge clk);
      check("rstmid busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid req",   {31'd0, rom_if.rom_req}, 32'd0);
      check("rstmid a_dat", {24'd0, adpcma_data}, 32'd0);
      check("rstmid b_dat", {24'd0, adpcmb_data}, 32'd0);
      check("rstmid busy0", {31'd0, busy}, 32'd0);
      rst_n = 1'b1; adpcmb_roe_n = 1'b1;
      rom_if.rom_ok = 1'b1; rom_if.rom_data = 8'hEE;
      @(negedge clk);
      rom_if.rom_ok = 1'b0; rom_if.rom_data = 8'h00;
      check("late ok b_dat", {24'd0, adpcmb_data}, 32'd0);
      check("late ok req",   {31'd0, rom_if.rom_req}, 32'd0);
      check("late ok busy",  {31'd0, busy}, 32'd0);
      adpcmb_roe_n = 1'b0;
      serve("refetch B", 25'h1000300, 1, 8'h91, rc);
      check("refetch B data", {24'd0, adpcmb_data}, 32'h91);
      adpcmb_roe_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
